ysyx_22050058_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the core's single memory port between instruction fetch (IF) and load/store (LS). It sits between the pipeline and the memory/ROM model in the top level. It accepts one transaction at a time, drives the memory port with a valid/ready handshake, and routes the response back to the owner. A response-timeout watchdog keeps a hung memory from stalling the core forever.

---
 rtl/ysyx_22050058_mem_arbiter_if.sv | 43 ++++
 rtl/ysyx_22050058_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_ysyx_22050058_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_mem_arbiter_if.sv
// ysyx_22050058_mem_arbiter_if: request, response and memory-port signals of the IF/LS memory arbiter.
// slave is the arbiter's view; master is the surrounding pipeline and memory model.
interface ysyx_22050058_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                if_req_valid_i;
    logic                if_req_ready_o;
    logic [ADDR_W-1:0]   if_addr_i;
    logic                if_resp_valid_o;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                ls_req_valid_i;
    logic                ls_req_ready_o;
    logic [ADDR_W-1:0]   ls_addr_i;
    logic                ls_wen_i;
    logic [DATA_W-1:0]   ls_wdata_i;
    logic [DATA_W/8-1:0] ls_wmask_i;
    logic                ls_resp_valid_o;
    logic [DATA_W-1:0]   ls_rdata_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic                mem_wen_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic [DATA_W/8-1:0] mem_wmask_o;
    logic                mem_resp_valid_i;
    logic [DATA_W-1:0]   mem_rdata_i;
    logic                err_o;

    modport slave (
        input  if_req_valid_i, if_addr_i, ls_req_valid_i, ls_addr_i, ls_wen_i, ls_wdata_i, ls_wmask_i,
               mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        output if_req_ready_o, if_resp_valid_o, if_rdata_o, ls_req_ready_o, ls_resp_valid_o, ls_rdata_o,
               mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, err_o
    );

    modport master (
        output if_req_valid_i, if_addr_i, ls_req_valid_i, ls_addr_i, ls_wen_i, ls_wdata_i, ls_wmask_i,
               mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        input  if_req_ready_o, if_resp_valid_o, if_rdata_o, ls_req_ready_o, ls_resp_valid_o, ls_rdata_o,
               mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, err_o
    );
endinterface

// File: rtl/ysyx_22050058_mem_arbiter.sv
// ysyx_22050058_mem_arbiter: shares one memory port between IF and LS with round-robin grant,
// one outstanding transaction and a response watchdog.
module ysyx_22050058_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    ysyx_22050058_mem_arbiter_if.slave bus
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e              state_q, state_d;
    logic                owner_ls_q, owner_ls_d;
    logic                last_ls_q, last_ls_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_rv_q, if_rv_d;
    logic                ls_rv_q, ls_rv_d;
    logic                err_q, err_d;
    logic                grant_ls, if_rdy, ls_rdy, tmo;
    logic [DATA_W-1:0]   rsp;

    // LS wins when alone, or when both ask and IF was the last one served
    assign grant_ls = bus.ls_req_valid_i && (!bus.if_req_valid_i || !last_ls_q);
    assign ls_rdy   = state_q == IDLE && grant_ls;
    assign if_rdy   = state_q == IDLE && bus.if_req_valid_i && !grant_ls;
    assign tmo      = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT) && !bus.mem_resp_valid_i;
    assign rsp      = bus.mem_resp_valid_i ? bus.mem_rdata_i : '0;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        last_ls_d  = last_ls_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_rv_d    = 1'b0;
        ls_rv_d    = 1'b0;
        err_d      = 1'b0;
        if (if_rdy || ls_rdy) begin
            state_d    = ISSUE;
            owner_ls_d = ls_rdy;
            last_ls_d  = ls_rdy;
            addr_d     = ls_rdy ? bus.ls_addr_i : bus.if_addr_i;
            wen_d      = ls_rdy && bus.ls_wen_i;
            wdata_d    = ls_rdy ? bus.ls_wdata_i : '0;
            wmask_d    = ls_rdy ? bus.ls_wmask_i : '0;
        end else if (state_q == ISSUE && bus.mem_req_ready_i) begin
            state_d = WAIT;
            cnt_d   = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_resp_valid_i || tmo) begin
                state_d    = IDLE;
                if_rv_d    = !owner_ls_q;
                ls_rv_d    = owner_ls_q;
                err_d      = tmo;
                if_rdata_d = owner_ls_q ? if_rdata_q : rsp;
                ls_rdata_d = owner_ls_q ? rsp : ls_rdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_rv_q    <= 1'b0;
            ls_rv_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_rv_q    <= if_rv_d;
            ls_rv_q    <= ls_rv_d;
            err_q      <= err_d;
        end
    end

    assign bus.if_req_ready_o  = if_rdy;
    assign bus.ls_req_ready_o  = ls_rdy;
    assign bus.if_resp_valid_o = if_rv_q;
    assign bus.ls_resp_valid_o = ls_rv_q;
    assign bus.if_rdata_o      = if_rdata_q;
    assign bus.ls_rdata_o      = ls_rdata_q;
    assign bus.mem_req_valid_o = state_q == ISSUE;
    assign bus.mem_addr_o      = addr_q;
    assign bus.mem_wen_o       = wen_q;
    assign bus.mem_wdata_o     = wdata_q;
    assign bus.mem_wmask_o     = wmask_q;
    assign bus.err_o           = err_q;
endmodule

// File: tb/tb_ysyx_22050058_mem_arbiter.sv
// tb_ysyx_22050058_mem_arbiter: vector table, randomized transactions against a transaction-level
// model, and hand-written round-robin and reset sequences.
module tb_ysyx_22050058_mem_arbiter;
    localparam int TMO = 8;

    typedef struct {
        logic        if_v, ls_v;
        logic [63:0] if_addr, ls_addr;
        logic        ls_wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          r, w;
        logic [63:0] rdata;
        logic        exp_ls;
        logic [63:0] exp_addr;
        logic        exp_wen;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        int          exp_lat;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic        chk_rd;
    } vec_t;

    logic clk, rst;
    int   n_cmp, n_err;
    logic last_ls;
    vec_t tbl[9];

    ysyx_22050058_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus();
    ysyx_22050058_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req_valid_i   = 1'b0;
        bus.if_addr_i        = '0;
        bus.ls_req_valid_i   = 1'b0;
        bus.ls_addr_i        = '0;
        bus.ls_wen_i         = 1'b0;
        bus.ls_wdata_i       = '0;
        bus.ls_wmask_i       = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_rdata_i      = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        last_ls = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_valid"}, bus.mem_req_valid_o, 0);
        check({tag, " if_resp"}, bus.if_resp_valid_o, 0);
        check({tag, " ls_resp"}, bus.ls_resp_valid_o, 0);
        check({tag, " err"}, bus.err_o, 0);
        check({tag, " mem_addr"}, bus.mem_addr_o, 0);
        check({tag, " mem_wdata"}, bus.mem_wdata_o, 0);
        check({tag, " if_rdata"}, bus.if_rdata_o, 0);
        check({tag, " ls_rdata"}, bus.ls_rdata_o, 0);
        check({tag, " ready"}, {bus.if_req_ready_o, bus.ls_req_ready_o}, 0);
    endtask

    function automatic vec_t mkv(input logic iv, lv, input logic [63:0] ia, la, input logic wen,
                                 input logic [63:0] wd, input logic [7:0] wm, input int r, w,
                                 input logic [63:0] rd, input logic e_ls, input int e_lat,
                                 input logic e_err, input logic [63:0] e_rd);
        vec_t v;
        v.if_v = iv; v.ls_v = lv; v.if_addr = ia; v.ls_addr = la; v.ls_wen = wen;
        v.wdata = wd; v.wmask = wm; v.r = r; v.w = w; v.rdata = rd;
        v.exp_ls = e_ls; v.exp_lat = e_lat; v.exp_err = e_err; v.exp_rdata = e_rd;
        v.exp_addr  = e_ls ? la : ia;
        v.exp_wen   = e_ls & wen;
        v.exp_wdata = e_ls ? wd : 64'h0;
        v.exp_wmask = e_ls ? wm : 8'h0;
        v.chk_rd    = !(e_ls && wen);
        return v;
    endfunction

    // Memory accepts r cycles late and answers w cycles into WAIT; checks every cycle of the transaction.
    task automatic run_txn(input vec_t v);
        int kmax, kr;
        kr = v.r + 2 + v.w;
        kmax = (v.exp_lat > kr ? v.exp_lat : kr) + 1;
        @(posedge clk); #1;
        bus.if_req_valid_i = v.if_v;
        bus.if_addr_i      = v.if_addr;
        bus.ls_req_valid_i = v.ls_v;
        bus.ls_addr_i      = v.ls_addr;
        bus.ls_wen_i       = v.ls_wen;
        bus.ls_wdata_i     = v.wdata;
        bus.ls_wmask_i     = v.wmask;
        @(negedge clk);
        check("if_ready", bus.if_req_ready_o, !v.exp_ls);
        check("ls_ready", bus.ls_req_ready_o, v.exp_ls);
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            bus.if_req_valid_i   = 1'b0;
            bus.ls_req_valid_i   = 1'b0;
            bus.mem_req_ready_i  = (k == v.r + 1);
            bus.mem_resp_valid_i = (k == kr);
            bus.mem_rdata_i      = (k == kr) ? v.rdata : {$urandom, $urandom};
            @(negedge clk);
            check("mem_valid", bus.mem_req_valid_o, k <= v.r + 1);
            if (k <= v.r + 1) begin
                check("mem_addr", bus.mem_addr_o, v.exp_addr);
                check("mem_wen", bus.mem_wen_o, v.exp_wen);
                check("mem_wdata", bus.mem_wdata_o, v.exp_wdata);
                check("mem_wmask", bus.mem_wmask_o, v.exp_wmask);
            end
            check("if_resp", bus.if_resp_valid_o, k == v.exp_lat && !v.exp_ls);
            check("ls_resp", bus.ls_resp_valid_o, k == v.exp_lat && v.exp_ls);
            check("err", bus.err_o, k == v.exp_lat && v.exp_err);
            if (k >= v.exp_lat && v.chk_rd)
                check("rdata", v.exp_ls ? bus.ls_rdata_o : bus.if_rdata_o, v.exp_rdata);
        end
        last_ls = v.exp_ls;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        clear_inputs();
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        //          iv    lv    if_addr          ls_addr          wen   wdata                  wmask  r  w   rdata                  ls    lat err  exp_rdata
        tbl[0] = mkv(1'b1, 1'b0, 64'h8000_0000, 64'h1234,        1'b1, 64'h5555,              8'hFF, 0, 0,  64'h13,                1'b0, 3,  1'b0, 64'h13);
        tbl[1] = mkv(1'b0, 1'b1, 64'h0,         64'h8000_0010,   1'b1, 64'hDEAD_BEEF,         8'h0F, 4, 0,  64'h99,                1'b1, 7,  1'b0, 64'h0);
        tbl[2] = mkv(1'b0, 1'b1, 64'h0,         64'h8000_0020,   1'b0, 64'h0,                 8'h00, 1, 3,  64'h1122334455667788,  1'b1, 7,  1'b0, 64'h1122334455667788);
        tbl[3] = mkv(1'b1, 1'b1, 64'h8000_0004, 64'h8000_0030,   1'b0, 64'h0,                 8'h00, 0, 1,  64'h73,                1'b0, 4,  1'b0, 64'h73);
        tbl[4] = mkv(1'b1, 1'b1, 64'h8000_0008, 64'h8000_0038,   1'b0, 64'h0,                 8'h00, 2, 2,  64'hCAFE,              1'b1, 7,  1'b0, 64'hCAFE);
        tbl[5] = mkv(1'b1, 1'b0, 64'h8000_000C, 64'h0,           1'b0, 64'h0,                 8'h00, 0, 8,  64'hABCD,              1'b0, 11, 1'b0, 64'hABCD);
        tbl[6] = mkv(1'b1, 1'b0, 64'h8000_0010, 64'h0,           1'b0, 64'h0,                 8'h00, 0, 9,  64'hBAD,               1'b0, 11, 1'b1, 64'h0);
        tbl[7] = mkv(1'b0, 1'b1, 64'h0,         64'h8000_0040,   1'b0, 64'h0,                 8'h00, 2, 40, 64'hBAD,               1'b1, 13, 1'b1, 64'h0);
        tbl[8] = mkv(1'b1, 1'b0, 64'h8000_0014, 64'h0,           1'b0, 64'h0,                 8'h00, 3, 7,  64'h77,                1'b0, 13, 1'b0, 64'h77);
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Random traffic: grant, latency and outcome come from the arbitration and watchdog rules.
        for (int i = 0; i < 120; i++) begin
            logic iv, lv, el, to, wen;
            int r, w;
            logic [63:0] ia, la, wd, rd;
            logic [7:0] wm;
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            el = (iv && lv) ? !last_ls : lv;
            r  = $urandom_range(0, 3);
            w  = $urandom_range(0, 11);
            to = w > TMO;
            ia = {$urandom, $urandom};
            la = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            wm = 8'($urandom);
            wen = 1'($urandom_range(0, 1));
            run_txn(mkv(iv, lv, ia, la, wen, wd, wm, r, w, rd, el, 3 + r + (to ? TMO : w), to, to ? 64'h0 : rd));
        end

        // Both requesters held valid from reset with a zero-wait memory: LS, IF, LS, IF.
        do_reset();
        bus.if_req_valid_i   = 1'b1;
        bus.if_addr_i        = 64'h8000_0000;
        bus.ls_req_valid_i   = 1'b1;
        bus.ls_addr_i        = 64'h8000_1000;
        bus.mem_req_ready_i  = 1'b1;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 64'h5A;
        for (int i = 0; i < 4; i++) begin
            logic g_ls;
            g_ls = (i % 2 == 0);
            @(negedge clk);
            check("rr ls_ready", bus.ls_req_ready_o, g_ls);
            check("rr if_ready", bus.if_req_ready_o, !g_ls);
            if (i > 0) begin
                check("rr if_resp", bus.if_resp_valid_o, g_ls);
                check("rr ls_resp", bus.ls_resp_valid_o, !g_ls);
            end
            @(negedge clk);
            check("rr mem_valid", bus.mem_req_valid_o, 1);
            check("rr mem_addr", bus.mem_addr_o, g_ls ? 64'h8000_1000 : 64'h8000_0000);
            @(negedge clk);
            check("rr wait", bus.mem_req_valid_o, 0);
        end

        // Reset while in WAIT drops the transaction; a later response is ignored.
        do_reset();
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 64'h8000_0100;
        @(posedge clk); #1;
        bus.if_req_valid_i  = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready_i = 1'b0;
        @(negedge clk);
        check("rw mem_addr", bus.mem_addr_o, 64'h8000_0100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 64'hFF;
        @(negedge clk);
        check_all_zero("rst_wait");
        @(posedge clk); #1;
        bus.mem_resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late if_resp", bus.if_resp_valid_o, 0);
            check("late ls_resp", bus.ls_resp_valid_o, 0);
            check("late err", bus.err_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
